// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path: FSM state encoding,
// PCM sample width, default PDM front-end constants and the CIC width helper.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int unsigned PCM_W       = 10;
    localparam int unsigned CLK_DIV_DEF = 100;
    localparam int unsigned DECIM_DEF   = 32;

    // Register width for a 2nd-order CIC with decimation decim: 2*log2(decim)+1.
    function automatic int unsigned cic_w(input int unsigned decim);
        return 2 * $clog2(decim) + 1;
    endfunction

endpackage : audio_pkg

// File: rtl/cic2_decim.sv
// Second-order CIC decimator: two integrators at the PDM bit rate, two combs
// at the decimated rate. Modular arithmetic, wrap-around is intentional.
module cic2_decim
    import audio_pkg::*;
#(
    parameter int unsigned DECIM = DECIM_DEF,
    parameter int unsigned W     = cic_w(DECIM)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         bit_tick,
    input  logic         bit_in,
    output logic [W-1:0] raw,
    output logic         raw_valid
);

    localparam int unsigned L = $clog2(DECIM);

    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic [W-1:0] i2_d;
    logic [W-1:0] c1_d;
    logic [L-1:0] bit_cnt;

    logic [W-1:0] i1_c;
    logic [W-1:0] i2_c;
    logic [W-1:0] c1_c;
    logic [W-1:0] c2_c;

    // Combs see the integrator values including the block-completing bit,
    // so the result is ready one clock after that bit tick.
    always_comb begin
        i1_c = i1 + W'(bit_in);
        i2_c = i2 + i1_c;
        c1_c = i2_c - i2_d;
        c2_c = c1_c - c1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1        <= '0;
            i2        <= '0;
            i2_d      <= '0;
            c1_d      <= '0;
            bit_cnt   <= '0;
            raw       <= '0;
            raw_valid <= 1'b0;
        end else if (clear) begin
            i1        <= '0;
            i2        <= '0;
            i2_d      <= '0;
            c1_d      <= '0;
            bit_cnt   <= '0;
            raw       <= '0;
            raw_valid <= 1'b0;
        end else begin
            raw_valid <= 1'b0;
            if (bit_tick) begin
                i1      <= i1_c;
                i2      <= i2_c;
                bit_cnt <= bit_cnt + L'(1);
                if (bit_cnt == L'(DECIM - 1)) begin
                    i2_d      <= i2_c;
                    c1_d      <= c1_c;
                    raw       <= c2_c;
                    raw_valid <= 1'b1;
                end
            end
        end
    end

endmodule : cic2_decim

// File: rtl/pdm_decimator.sv
// PDM microphone front-end: mic clock divider, capture FSM, CIC decimation and
// output scaling. Define PDM_DC_BLOCK_EN to add the running-mean DC blocker.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned DECIM    = DECIM_DEF,
    parameter int unsigned OUT_W    = PCM_W,
    parameter int unsigned SETTLE_N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             micData,
    output logic             micClk,
    output logic             micLRSel,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    output logic             busy
);

    localparam int unsigned L     = $clog2(DECIM);
    localparam int unsigned W     = cic_w(DECIM);
    localparam int unsigned SHIFT = 2 * L - OUT_W;
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned SET_W = (SETTLE_N < 1) ? 1 : $clog2(SETTLE_N + 1);
    localparam logic [OUT_W-1:0] PCM_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_nxt;

    logic             bit_tick_c;
    logic             emit_c;
    logic [W-1:0]     raw;
    logic             raw_valid;
    logic [W-1:0]     shifted_c;
    logic [OUT_W-1:0] scaled_c;

    assign micLRSel = 1'b0;

    // Next-state, divider and settle-count logic.
    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        settle_nxt = settle_cnt;
        emit_c     = 1'b0;

        if (state != IDLE)
            div_nxt = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (enable)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                settle_nxt = '0;
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_N))
                    state_nxt = RUN;
                else if (raw_valid)
                    settle_nxt = settle_cnt + SET_W'(1);
            end
            RUN: begin
                emit_c = raw_valid;
            end
            default: state_nxt = IDLE;
        endcase

        // Disable wins everywhere and drops anything in flight.
        if (state != IDLE && !enable) begin
            state_nxt = IDLE;
            emit_c    = 1'b0;
        end
        if (state_nxt == IDLE)
            div_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            settle_cnt <= '0;
            micClk     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            settle_cnt <= settle_nxt;
            micClk     <= (state_nxt != IDLE) && (div_nxt < DIV_W'(HALF));
            busy       <= (state_nxt != IDLE);
        end
    end

    // Sample micData at the end of the mic clock high phase.
    assign bit_tick_c = ((state == SETTLE) || (state == RUN)) && (div_cnt == DIV_W'(HALF - 1));

    cic2_decim #(
        .DECIM (DECIM),
        .W     (W)
    ) u_cic (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == CLEAR),
        .bit_tick  (bit_tick_c),
        .bit_in    (micData),
        .raw       (raw),
        .raw_valid (raw_valid)
    );

    // Full-scale input gives DECIM^2, one past the top code, hence the clamp.
    always_comb begin
        shifted_c = raw >> SHIFT;
        scaled_c  = (shifted_c > W'(PCM_MAX)) ? PCM_MAX : shifted_c[OUT_W-1:0];
    end

`ifdef PDM_DC_BLOCK_EN
    localparam int unsigned A_W = OUT_W + 2;
    localparam logic signed [A_W-1:0] AVG_INIT  = A_W'(2 ** (OUT_W - 1));
    localparam logic signed [A_W-1:0] PCM_MAX_S = A_W'(2 ** OUT_W - 1);

    logic signed [A_W-1:0] avg;
    logic [OUT_W-1:0]      sc_q;
    logic                  sc_emit;
    logic                  sc_upd;
    logic                  upd_c;
    logic                  live_c;
    logic signed [A_W-1:0] diff_c;
    logic signed [A_W-1:0] dc_out_c;
    logic [OUT_W-1:0]      dc_pcm_c;

    assign upd_c  = raw_valid && enable && ((state == SETTLE) || (state == RUN));
    assign live_c = enable && (state != IDLE);

    always_comb begin
        diff_c   = $signed({2'b00, sc_q}) - avg;
        dc_out_c = diff_c + AVG_INIT;
        if (dc_out_c < 0)
            dc_pcm_c = '0;
        else if (dc_out_c > PCM_MAX_S)
            dc_pcm_c = PCM_MAX;
        else
            dc_pcm_c = dc_out_c[OUT_W-1:0];
    end

    // Extra stage: scaled sample, then mean removal and mean update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg       <= AVG_INIT;
            sc_q      <= '0;
            sc_emit   <= 1'b0;
            sc_upd    <= 1'b0;
            pcm_valid <= 1'b0;
            pcm_data  <= '0;
        end else begin
            sc_emit   <= emit_c;
            sc_upd    <= upd_c;
            if (raw_valid)
                sc_q <= scaled_c;
            if (state == CLEAR)
                avg <= AVG_INIT;
            else if (sc_upd && live_c)
                avg <= avg + (diff_c >>> 6);
            pcm_valid <= sc_emit && live_c;
            if (sc_emit && live_c)
                pcm_data <= dc_pcm_c;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_valid <= 1'b0;
            pcm_data  <= '0;
        end else begin
            pcm_valid <= emit_c;
            if (emit_c)
                pcm_data <= scaled_c;
        end
    end
`endif

endmodule : pdm_decimator

// File: tb/tb_pdm_decimator.sv
// Directed self-checking bench for pdm_decimator at default parameters.
module tb_pdm_decimator;

    // busy rises in CLEAR; first tick 48 clk into SETTLE, 95 more ticks,
    // then 2 clk of pipeline: 1 + 48 + 9500 + 2.
    localparam int unsigned FIRST_LAT = 9551;
    localparam int unsigned STRB_PER  = 3200;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       micData;
    logic       micClk;
    logic       micLRSel;
    logic [9:0] pcm_data;
    logic       pcm_valid;
    logic       busy;

    int unsigned vectors;
    int unsigned miscompares;
    logic        mic_prev;
    logic        alt_mode;
    logic        prev_valid;

    pdm_decimator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .micData   (micData),
        .micClk    (micClk),
        .micLRSel  (micLRSel),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; inputs changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (alt_mode && mic_prev && !micClk)
            micData = ~micData;
        mic_prev = micClk;
    endtask

    task automatic wait_valid(input int unsigned budget, output int unsigned n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pcm_valid && n < budget);
    endtask

    // From enable already high: wait for busy, then time the first strobe.
    task automatic run_first(input string tag, input logic [31:0] exp_data);
        int unsigned n;
        int unsigned k;
        k = 0;
        while (!busy && k < 4) begin
            step();
            k++;
        end
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(FIRST_LAT + 200, n);
        check_eq({tag, "_lat"}, n, FIRST_LAT);
        check_eq({tag, "_data"}, 32'(pcm_data), exp_data);
    endtask

    always @(negedge clk) begin
        check_eq("lrsel", 32'(micLRSel), 32'd0);
        check_eq("valid_2cyc", 32'(prev_valid & pcm_valid), 32'd0);
        prev_valid = pcm_valid;
    end

    initial begin
        int unsigned n;
        int unsigned falls;
        int unsigned hi;
        int unsigned per;
        int unsigned vcount;
        logic        p;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        micData     = 1'b0;
        alt_mode    = 1'b0;
        mic_prev    = 1'b0;
        prev_valid  = 1'b0;

        repeat (3) step();
        check_eq("rst_micclk", 32'(micClk), 32'd0);
        check_eq("rst_data", 32'(pcm_data), 32'd0);
        check_eq("rst_valid", 32'(pcm_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_lrsel", 32'(micLRSel), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_micclk", 32'(micClk), 32'd0);

        // All ones: saturated full scale.
        micData = 1'b1;
        enable  = 1'b1;
        run_first("ones", 32'd1023);
        wait_valid(STRB_PER + 200, n);
        check_eq("ones_per", n, STRB_PER);
        check_eq("ones_data2", 32'(pcm_data), 32'd1023);

        // Mic clock: 50 clk high, 100 clk period.
        n = 0;
        p = micClk;
        do begin
            p = micClk;
            step();
            n++;
        end while (!(!p && micClk) && n < 300);
        hi = 0;
        while (micClk && hi < 300) begin
            hi++;
            step();
        end
        per = hi;
        while (!micClk && per < 300) begin
            per++;
            step();
        end
        check_eq("micclk_high", hi, 32'd50);
        check_eq("micclk_per", per, 32'd100);
        wait_valid(STRB_PER + 200, n);
        check_eq("ones_data3", 32'(pcm_data), 32'd1023);

        // Drop enable with 17 bits of the current block taken.
        falls = 0;
        n = 0;
        while (falls < 17 && n < 2500) begin
            p = micClk;
            step();
            n++;
            if (p && !micClk)
                falls++;
        end
        check_eq("drop_falls", falls, 32'd17);
        repeat (10) step();
        enable = 1'b0;
        step();
        check_eq("drop_busy", 32'(busy), 32'd0);
        check_eq("drop_micclk", 32'(micClk), 32'd0);
        vcount = 32'(pcm_valid);
        repeat (1600) begin
            step();
            vcount += 32'(pcm_valid);
        end
        check_eq("drop_novalid", vcount, 32'd0);
        check_eq("drop_hold", 32'(pcm_data), 32'd1023);

        // Re-enable must time exactly like a cold start.
        enable = 1'b1;
        run_first("reen", 32'd1023);

        // All zeros.
        enable = 1'b0;
        step();
        micData = 1'b0;
        enable  = 1'b1;
        run_first("zero", 32'd0);
        wait_valid(STRB_PER + 200, n);
        check_eq("zero_per", n, STRB_PER);
        check_eq("zero_data2", 32'(pcm_data), 32'd0);

        // Alternating 1,0 per bit: half scale.
        enable = 1'b0;
        step();
        alt_mode = 1'b1;
        enable   = 1'b1;
        run_first("alt", 32'd512);
        wait_valid(STRB_PER + 200, n);
        check_eq("alt_per", n, STRB_PER);
        check_eq("alt_data2", 32'(pcm_data), 32'd512);

        // Asynchronous reset mid-run, off the clock edge.
        repeat (37) step();
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_micclk", 32'(micClk), 32'd0);
        check_eq("arst_data", 32'(pcm_data), 32'd0);
        check_eq("arst_valid", 32'(pcm_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        run_first("arst", 32'd512);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pdm_decimator
